// File: rtl/fsk_pkg.sv
// Shared constants, defaults and state type for the FSK demodulator.
package fsk_pkg;

    localparam logic [15:0] MIDSCALE = 16'd32768;

    localparam int unsigned NB_DEF       = 256;
    localparam int unsigned IDLE_MIN_DEF = 64;
    localparam int unsigned ONE_MAX_DEF  = 2;
    localparam int unsigned ZERO_MAX_DEF = 6;

    localparam int unsigned        XCNT_W   = 4;
    localparam logic [XCNT_W-1:0]  XCNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE_WAIT = 2'd0,
        ARMED     = 2'd1,
        RX_BIT    = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/fsk_cross_det.sv
// Sample register, sign-bit crossing pulse and saturating midscale run counter.
module fsk_cross_det
    import fsk_pkg::*;
#(
    parameter int unsigned IDLE_MIN = IDLE_MIN_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] sample_i,
    input  logic        run_clr_i,
    output logic        cross_c_o,
    output logic        mid_c_o,
    output logic        idle_o
);

    localparam int unsigned RUN_W = $clog2(IDLE_MIN + 1);

    logic [15:0]      prev_sample_q;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             idle_q, idle_d;

    assign cross_c_o = sample_i[15] ^ prev_sample_q[15];
    assign mid_c_o   = (sample_i == MIDSCALE);
    assign idle_o    = idle_q;

    // idle_q mirrors run_cnt_q == IDLE_MIN so the FSM sees a registered flag
    always_comb begin
        run_cnt_d = '0;
        if (!run_clr_i && mid_c_o) begin
            run_cnt_d = (run_cnt_q == RUN_W'(IDLE_MIN)) ? run_cnt_q : run_cnt_q + RUN_W'(1);
        end
        idle_d = (run_cnt_d == RUN_W'(IDLE_MIN));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_sample_q <= MIDSCALE;
            run_cnt_q     <= '0;
            idle_q        <= 1'b0;
        end else begin
            prev_sample_q <= sample_i;
            run_cnt_q     <= run_cnt_d;
            idle_q        <= idle_d;
        end
    end

endmodule

// File: rtl/fsk_demodulator.sv
// Crossing-count FSK demodulator: idle-qualified 8-bit LSB-first frames of NB samples per bit.
// Define FSK_DEMOD_FRAME_ERR_EN to enable the sticky frame error flag.
module fsk_demodulator
    import fsk_pkg::*;
#(
    parameter int unsigned NB       = NB_DEF,
    parameter int unsigned IDLE_MIN = IDLE_MIN_DEF,
    parameter int unsigned ONE_MAX  = ONE_MAX_DEF,
    parameter int unsigned ZERO_MAX = ZERO_MAX_DEF
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [15:0] signal,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        frame_err
);

    localparam int unsigned WIN_W = (NB > 1) ? $clog2(NB) : 1;

    state_t            state_q, state_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [XCNT_W-1:0] xcnt_q, xcnt_d, xcnt_inc;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              cross_c, mid_c, idle, win_last, bad_c, bit_val;

    fsk_cross_det #(
        .IDLE_MIN (IDLE_MIN)
    ) u_cross_det (
        .clk_i     (CLOCK_50),
        .rst_i     (reset),
        .sample_i  (signal),
        .run_clr_i (state_q == DONE),
        .cross_c_o (cross_c),
        .mid_c_o   (mid_c),
        .idle_o    (idle)
    );

    // Closing sample's crossing is folded in before the window decision
    assign xcnt_inc = (cross_c && (xcnt_q != XCNT_MAX)) ? xcnt_q + XCNT_W'(1) : xcnt_q;
    assign win_last = (win_cnt_q == WIN_W'(NB - 1));
    assign bad_c    = (xcnt_inc == '0) || (32'(xcnt_inc) > ZERO_MAX);
    assign bit_val  = !bad_c && (32'(xcnt_inc) <= ONE_MAX);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state_q <= IDLE_WAIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_WAIT: if (idle) state_d = ARMED;
            ARMED:     if (!mid_c) state_d = RX_BIT;
            RX_BIT: begin
                if (idle)                                 state_d = ARMED;
                else if (win_last && bit_idx_q == 3'd7)   state_d = DONE;
            end
            DONE:      state_d = IDLE_WAIT;
            default:   state_d = IDLE_WAIT;
        endcase
    end

    // The arming sample is sample 0 of bit 0; its step out of midscale is not a data crossing
    always_comb begin
        win_cnt_d    = win_cnt_q;
        xcnt_d       = xcnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        case (state_q)
            ARMED: begin
                if (!mid_c) begin
                    win_cnt_d = WIN_W'(1);
                    xcnt_d    = '0;
                    bit_idx_d = '0;
                end
            end
            RX_BIT: begin
                if (!idle) begin
                    if (win_last) begin
                        shift_d[bit_idx_q] = bit_val;
                        win_cnt_d          = '0;
                        xcnt_d             = '0;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            data_out_d   = shift_d;
                            data_valid_d = 1'b1;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        xcnt_d    = xcnt_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            win_cnt_q    <= '0;
            xcnt_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            xcnt_q       <= xcnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

`ifdef FSK_DEMOD_FRAME_ERR_EN
    logic err_q, err_d;
    logic frame_err_q, frame_err_d;

    // Sticky across the frame, presented alongside the data strobe
    always_comb begin
        err_d       = err_q;
        frame_err_d = 1'b0;
        case (state_q)
            ARMED: if (!mid_c) err_d = 1'b0;
            RX_BIT: begin
                if (!idle && win_last) begin
                    err_d = err_q | bad_c;
                    if (bit_idx_q == 3'd7) frame_err_d = err_q | bad_c;
                end
            end
            DONE:    err_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            err_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            err_q       <= err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_fsk_demodulator.sv
// Randomised bench for fsk_demodulator with a frame-level reference model and directed scenarios.
module tb_fsk_demodulator;
    import fsk_pkg::*;

    localparam int unsigned NB       = 256;
    localparam int unsigned IDLE_MIN = 64;
    localparam int unsigned ONE_MAX  = 2;
    localparam int unsigned ZERO_MAX = 6;
    localparam logic [15:0] MID = 16'd32768;
    localparam logic [15:0] HI  = 16'd40768;
    localparam logic [15:0] LO  = 16'd24768;
`ifdef FSK_DEMOD_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [15:0] signal;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        frame_err;

    always #10 CLOCK_50 = ~CLOCK_50;

    fsk_demodulator #(
        .NB       (NB),
        .IDLE_MIN (IDLE_MIN),
        .ONE_MAX  (ONE_MAX),
        .ZERO_MAX (ZERO_MAX)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .signal     (signal),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: frame-level view of the sample stream
    typedef enum int {M_HUNT, M_ARMED, M_FRAME, M_EMIT} mphase_t;
    mphase_t     m_phase;
    int          m_run;
    logic [15:0] m_frame[$];
    logic [7:0]  m_dout;
    logic        m_dv, m_fe;

    logic [7:0]  sb_data[$];
    logic        sb_err[$];
    int          sb_cyc[$];
    logic [7:0]  g_ph;

    function automatic void model_reset();
        m_phase = M_HUNT;
        m_run   = 0;
        m_frame.delete();
        m_dout  = 8'h00;
        m_dv    = 1'b0;
        m_fe    = 1'b0;
    endfunction

    // Count sign changes inside each NB-sample window of the captured frame
    function automatic void decode(output logic [7:0] d, output logic e);
        logic [15:0] a, b;
        int x;
        d = 8'h00;
        e = 1'b0;
        for (int bi = 0; bi < 8; bi++) begin
            x = 0;
            for (int k = 0; k < int'(NB); k++) begin
                int i = bi * int'(NB) + k;
                if (i > 0) begin
                    a = m_frame[i];
                    b = m_frame[i-1];
                    if (a[15] != b[15]) x++;
                end
            end
            if (x > 15) x = 15;
            if (x >= 1 && x <= int'(ONE_MAX)) d[bi] = 1'b1;
            if (x == 0 || x > int'(ZERO_MAX)) e = ERR_EN;
        end
    endfunction

    function automatic void model_step(input logic [15:0] s);
        bit mid = (s == MID);
        int run_old = m_run;
        bit clr = 1'b0;
        logic [7:0] d;
        logic e;
        m_dv = 1'b0;
        m_fe = 1'b0;
        case (m_phase)
            M_HUNT:  if (run_old == int'(IDLE_MIN)) m_phase = M_ARMED;
            M_ARMED: if (!mid) begin
                m_frame.delete();
                m_frame.push_back(s);
                m_phase = M_FRAME;
            end
            M_FRAME: begin
                if (run_old == int'(IDLE_MIN)) m_phase = M_ARMED;
                else begin
                    m_frame.push_back(s);
                    if (m_frame.size() == 8 * NB) begin
                        decode(d, e);
                        m_dout  = d;
                        m_dv    = 1'b1;
                        m_fe    = e;
                        m_phase = M_EMIT;
                    end
                end
            end
            M_EMIT: begin
                m_phase = M_HUNT;
                clr     = 1'b1;
            end
            default: m_phase = M_HUNT;
        endcase
        if (clr || !mid)                    m_run = 0;
        else if (run_old < int'(IDLE_MIN)) m_run = run_old + 1;
    endfunction

    // Per-cycle compare against the model, sampled 1 ns after the active edge
    always @(posedge CLOCK_50) begin : cmp
        logic [15:0] s;
        logic        r;
        s = signal;
        r = reset;
        if (r) model_reset();
        else   model_step(s);
        #1;
        checks++;
        if (data_valid !== m_dv || data_out !== m_dout || frame_err !== m_fe) begin
            errors++;
            $display("FAIL cycle %0d outputs: dv=%b dout=%h ferr=%b required dv=%b dout=%h ferr=%b",
                     cyc, data_valid, data_out, frame_err, m_dv, m_dout, m_fe);
        end
        if (data_valid === 1'b1) begin
            sb_data.push_back(data_out);
            sb_err.push_back(frame_err);
            sb_cyc.push_back(cyc);
        end
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] v);
        @(negedge CLOCK_50);
        signal = v;
    endtask

    task automatic send_idle(input int n);
        repeat (n) drive(MID);
    endtask

    // Square-wave generator: phase advances by step per sample, bit 7 of phase selects polarity
    task automatic send_part(input int step, input int n);
        for (int k = 0; k < n; k++) begin
            drive(g_ph[7] ? LO : HI);
            g_ph = g_ph + 8'(step);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        g_ph = 8'h00;
        for (int i = 0; i < 8; i++) send_part(b[i] ? 1 : 2, int'(NB));
    endtask

    task automatic send_random_frame();
        int burst_bit = int'($urandom_range(0, 15));
        g_ph = 8'($urandom);
        for (int bi = 0; bi < 8; bi++) begin
            int st = int'($urandom_range(0, 7));
            if (bi == burst_bit) begin
                send_part(st, 100);
                send_idle(int'($urandom_range(10, 100)));
                send_part(st, int'(NB) - 100);
            end else begin
                send_part(st, int'(NB));
            end
        end
        send_idle(int'($urandom_range(40, 300)));
    endtask

    initial begin : stim
        int n0;
        logic [7:0] v55;
        reset  = 1'b1;
        signal = MID;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_dv", 32'(data_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE_WAIT));

        // Single 0xAC frame
        n0 = sb_data.size();
        send_idle(100);
        send_byte(8'hAC);
        send_idle(256);
        chk("ac_strobes", 32'(sb_data.size() - n0), 32'd1);
        chk("ac_data", 32'(sb_data[sb_data.size()-1]), 32'hAC);
        chk("ac_ferr", 32'(sb_err[sb_err.size()-1]), 32'h0);
        chk("ac_hold", 32'(data_out), 32'hAC);

        // Back-to-back 0x00 then 0xFF
        n0 = sb_data.size();
        send_byte(8'h00);
        send_idle(256);
        send_byte(8'hFF);
        send_idle(256);
        chk("b2b_strobes", 32'(sb_data.size() - n0), 32'd2);
        chk("b2b_first", 32'(sb_data[n0]), 32'h00);
        chk("b2b_second", 32'(sb_data[n0+1]), 32'hFF);
        chk("b2b_spacing", 32'(sb_cyc[n0+1] - sb_cyc[n0]), 32'd2304);

        // Long midscale hold
        n0 = sb_data.size();
        send_idle(10000);
        chk("idle_strobes", 32'(sb_data.size() - n0), 32'd0);

        // Reset during bit 4 of 0xAC
        n0 = sb_data.size();
        send_idle(100);
        g_ph = 8'h00;
        send_part(2, int'(NB));
        send_part(2, int'(NB));
        send_part(1, int'(NB));
        send_part(1, int'(NB));
        send_part(2, 128);
        chk("pre_rst_dout", 32'(data_out), 32'hFF);
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        chk("mid_rst_dout", 32'(data_out), 32'h0);
        chk("mid_rst_dv", 32'(data_valid), 32'h0);
        chk("mid_rst_ferr", 32'(frame_err), 32'h0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE_WAIT));
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        send_part(2, 128);
        send_part(1, int'(NB));
        send_part(2, int'(NB));
        send_part(1, int'(NB));
        chk("rst_partial_strobes", 32'(sb_data.size() - n0), 32'd0);
        send_idle(256);
        send_byte(8'hAC);
        send_idle(256);
        chk("post_rst_strobes", 32'(sb_data.size() - n0), 32'd1);
        chk("post_rst_data", 32'(sb_data[sb_data.size()-1]), 32'hAC);

        // Flat below-midscale frame: no crossings anywhere
        n0 = sb_data.size();
        send_idle(100);
        repeat (2048) drive(16'd1000);
        send_idle(256);
        chk("flat_strobes", 32'(sb_data.size() - n0), 32'd1);
        chk("flat_data", 32'(sb_data[sb_data.size()-1]), 32'h00);
        chk("flat_ferr", 32'(sb_err[sb_err.size()-1]), 32'(ERR_EN));

        // 0x55 with a midscale burst during bit 2
        n0  = sb_data.size();
        v55 = 8'h55;
        send_idle(100);
        g_ph = 8'h00;
        send_part(1, int'(NB));
        send_part(2, int'(NB));
        send_part(1, 100);
        send_idle(200);
        chk("abort_state", 32'(dut.state_q), 32'(ARMED));
        send_part(1, int'(NB) - 100);
        for (int bi = 3; bi < 8; bi++) send_part(v55[bi] ? 1 : 2, int'(NB));
        send_idle(256);
        chk("abort_strobes", 32'(sb_data.size() - n0), 32'd0);
        chk("abort_end_state", 32'(dut.state_q), 32'(ARMED));

        // Randomised frames
        repeat (12) send_random_frame();

        repeat (2) @(negedge CLOCK_50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
